busca_instrucao: RTL

//  Instruction-fetch stage between PC and decode. Takes the PC value and issues a read
//  to instruction memory, which may take a variable number of cycles. Buffers returned

---
 rtl/busca_instrucao.sv | 122 ++++++++++++
 1 files changed

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: issues one read at a time to instruction memory,
// buffers returned words in a small show-ahead FIFO and presents them to
// decode with valid/ready. Holds the PC while waiting or after fetching HLT.
module busca_instrucao #(
   parameter int          LARGURA      = 32,
   parameter int          PROFUNDIDADE = 2,
   parameter logic [5:0]  HLT_OPCODE   = 6'b111111
) (
   input  logic               clock,
   input  logic               reseta,
   input  logic [LARGURA-1:0] pc_endereco,
   input  logic               jump,
   output logic               halt,
   output logic               mem_leitura,
   output logic [LARGURA-1:0] mem_endereco,
   input  logic [LARGURA-1:0] mem_dado,
   input  logic               mem_valido,
   output logic [LARGURA-1:0] instrucao,
   output logic [LARGURA-1:0] instr_pc,
   output logic               instr_valida,
   input  logic               decod_pronto
);

   localparam int             PW    = $clog2(PROFUNDIDADE);
   localparam logic [PW:0]    CHEIO = (PW+1)'(PROFUNDIDADE);

   typedef enum logic [1:0] {OCIOSO, ESPERA, PARADO} estado_t;

   estado_t             estado, prox_estado;
   logic                descarta;
   logic [LARGURA-1:0]  req_pc;

   logic [LARGURA-1:0]  fifo_instr [PROFUNDIDADE];
   logic [LARGURA-1:0]  fifo_pc    [PROFUNDIDADE];
   logic [PW-1:0]       cabeca, cauda;
   logic [PW:0]         contagem;

   logic                emitir, empilha, desempilha, e_hlt;

   // Opcode field sits in the top six bits of the word
   assign e_hlt = (mem_dado[LARGURA-1 -: 6] == HLT_OPCODE);

   // State register
   always_ff @(posedge clock or negedge reseta) begin
      if (!reseta) estado <= OCIOSO;
      else         estado <= prox_estado;
   end

   // Next-state logic; a jump in ESPERA without data keeps waiting for the stale word
   always_comb begin
      prox_estado = estado;
      case (estado)
         OCIOSO: if (emitir) prox_estado = ESPERA;
         ESPERA: begin
            if (mem_valido) begin
               if (descarta || jump) prox_estado = OCIOSO;
               else if (e_hlt)       prox_estado = PARADO;
               else                  prox_estado = OCIOSO;
            end
         end
         PARADO: if (jump) prox_estado = OCIOSO;
         default: prox_estado = OCIOSO;
      endcase
   end

   // Outputs and FIFO strobes; slot is reserved at issue so a push never overflows
   always_comb begin
      emitir       = reseta && (estado == OCIOSO) && (contagem < CHEIO) && !jump;
      mem_leitura  = emitir;
      halt         = !emitir;
      mem_endereco = emitir ? pc_endereco : '0;
      empilha      = (estado == ESPERA) && mem_valido && !descarta && !jump;
      instr_valida = (contagem != '0);
      desempilha   = instr_valida && decod_pronto && !jump;
      instrucao    = instr_valida ? fifo_instr[cabeca] : '0;
      instr_pc     = instr_valida ? fifo_pc[cabeca]    : '0;
   end

   // Request PC and the discard flag for a read made stale by a jump
   always_ff @(posedge clock or negedge reseta) begin
      if (!reseta) begin
         req_pc   <= '0;
         descarta <= 1'b0;
      end else begin
         if (emitir) req_pc <= pc_endereco;
         if (estado == ESPERA) begin
            if (mem_valido) descarta <= 1'b0;
            else if (jump)  descarta <= 1'b1;
         end
      end
   end

   // Circular FIFO; a jump flushes it and voids any pop in that cycle
   always_ff @(posedge clock or negedge reseta) begin
      if (!reseta) begin
         cabeca   <= '0;
         cauda    <= '0;
         contagem <= '0;
         for (int i = 0; i < PROFUNDIDADE; i++) begin
            fifo_instr[i] <= '0;
            fifo_pc[i]    <= '0;
         end
      end else if (jump) begin
         cabeca   <= '0;
         cauda    <= '0;
         contagem <= '0;
      end else begin
         if (empilha) begin
            fifo_instr[cauda] <= mem_dado;
            fifo_pc[cauda]    <= req_pc;
            cauda             <= cauda + 1'b1;
         end
         if (desempilha) cabeca <= cabeca + 1'b1;
         case ({empilha, desempilha})
            2'b10:   contagem <= contagem + 1'b1;
            2'b01:   contagem <= contagem - 1'b1;
            default: contagem <= contagem;
         endcase
      end
   end

endmodule
